sram_arb_nport: RTL and testbench

SRAM_ARB_NPORT -- requirements
Module: sram_arb_nport

---
 rtl/sram_arb_nport.sv | 132 +++++++++++++
 tb/tb_sram_arb_nport.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb_nport.sv
//==============================================================================
// Module   : sram_arb_nport
// Brief    : NUM_CH-way round-robin arbiter onto one single-port SRAM with
//            in-order response routing. Optional macro SRAM_ARB_WR_ACK_EN
//            makes writes return a response pulse as well.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sram_arb_nport #(
    parameter int NUM_CH         = 4,
    parameter int DATA_BUS_WIDTH = 64,
    parameter int ADDR_BUS_WIDTH = 64,
    parameter int RD_LATENCY     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CH-1:0]                req_valid,
    output logic [NUM_CH-1:0]                req_ready,
    input  logic [NUM_CH-1:0]                req_we,
    input  logic [NUM_CH*ADDR_BUS_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*DATA_BUS_WIDTH-1:0] req_wdata,
    output logic [NUM_CH-1:0]                rsp_valid,
    output logic [DATA_BUS_WIDTH-1:0]        rsp_rdata,
    output logic                             mem_sram_CEN,
    output logic [ADDR_BUS_WIDTH-1:0]        mem_sram_A,
    output logic [DATA_BUS_WIDTH-1:0]        mem_sram_D,
    output logic                             mem_sram_GWEN,
    input  logic [DATA_BUS_WIDTH-1:0]        mem_sram_Q,
    output logic                             busy
);
    localparam int c_PTR_W = $clog2(NUM_CH);
    localparam int c_LAST  = RD_LATENCY - 1;

    logic [c_PTR_W-1:0]    r_rr_ptr;
    logic [c_PTR_W-1:0]    w_gnt_idx;
    logic                  w_gnt;
    logic                  w_gnt_rd;
    logic                  w_tag_in;
    logic [RD_LATENCY-1:0] r_tag_vld;
    logic [RD_LATENCY-1:0] r_tag_rd;
    logic [c_PTR_W-1:0]    r_tag_ch [RD_LATENCY];

    // Upward search from the pointer; the first hit wins.
    always_comb begin
        logic [c_PTR_W-1:0] idx;
        w_gnt     = 1'b0;
        w_gnt_idx = '0;
        idx       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = c_PTR_W'((int'(r_rr_ptr) + k) % NUM_CH);
            if (!w_gnt && req_valid[idx]) begin
                w_gnt     = 1'b1;
                w_gnt_idx = idx;
            end
        end
        if (!rst_n) begin
            w_gnt = 1'b0;
        end
    end

    always_comb begin
        req_ready  = '0;
        mem_sram_A = '0;
        mem_sram_D = '0;
        w_gnt_rd   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_gnt && (w_gnt_idx == c_PTR_W'(k))) begin
                req_ready[k] = 1'b1;
                mem_sram_A   = req_addr[k*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
                mem_sram_D   = req_wdata[k*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
                w_gnt_rd     = ~req_we[k];
            end
        end
    end

    assign mem_sram_CEN  = ~w_gnt;
    assign mem_sram_GWEN = ~w_gnt | w_gnt_rd;

`ifdef SRAM_ARB_WR_ACK_EN
    assign w_tag_in = w_gnt;
`else
    assign w_tag_in = w_gnt & w_gnt_rd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_gnt) begin
            r_rr_ptr <= (w_gnt_idx == c_PTR_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Tag shift register tracks grant order; it mirrors the SRAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            r_tag_rd  <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                r_tag_ch[s] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_tag_in;
            r_tag_rd[0]  <= w_gnt_rd;
            r_tag_ch[0]  <= w_gnt_idx;
            for (int s = 1; s < RD_LATENCY; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_rd[s]  <= r_tag_rd[s-1];
                r_tag_ch[s]  <= r_tag_ch[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_tag_vld[c_LAST] && (r_tag_ch[c_LAST] == c_PTR_W'(k))) begin
                rsp_valid[k] = 1'b1;
            end
        end
        // Write acknowledges carry zero data.
        if (r_tag_vld[c_LAST] && r_tag_rd[c_LAST]) begin
            rsp_rdata = mem_sram_Q;
        end
    end

    assign busy = |r_tag_vld;

endmodule

`default_nettype wire

// File: tb/tb_sram_arb_nport.sv
//==============================================================================
// Module   : tb_sram_arb_nport
// Brief    : Bench for sram_arb_nport: latency-1 instance against a queue
//            based reference model, latency-3 instance with directed steps.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sram_arb_nport;
    localparam int NCH  = 4;
    localparam int DW   = 64;
    localparam int AW   = 64;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // latency-1 instance
    logic              rst_n;
    logic [NCH-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [DW-1:0]     rsp_rdata, mem_d, mem_q;
    logic [AW-1:0]     mem_a;
    logic              mem_cen, mem_gwen, busy;

    // latency-3 instance
    logic              rst3_n;
    logic [NCH-1:0]    v3, rdy3, we3, rsp3;
    logic [NCH*AW-1:0] a3;
    logic [NCH*DW-1:0] d3;
    logic [DW-1:0]     rdata3, mem_d3, mem_q3;
    logic [AW-1:0]     mem_a3;
    logic              mem_cen3, mem_gwen3, busy3;

    sram_arb_nport #(.NUM_CH(NCH), .DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .RD_LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_sram_CEN(mem_cen),
        .mem_sram_A(mem_a), .mem_sram_D(mem_d), .mem_sram_GWEN(mem_gwen),
        .mem_sram_Q(mem_q), .busy(busy));

    sram_arb_nport #(.NUM_CH(NCH), .DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .RD_LATENCY(LAT3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_ready(rdy3),
        .req_we(we3), .req_addr(a3), .req_wdata(d3),
        .rsp_valid(rsp3), .rsp_rdata(rdata3), .mem_sram_CEN(mem_cen3),
        .mem_sram_A(mem_a3), .mem_sram_D(mem_d3), .mem_sram_GWEN(mem_gwen3),
        .mem_sram_Q(mem_q3), .busy(busy3));

    // SRAM behaviour: synchronous array, Q delayed through a latency pipe
    logic [DW-1:0] sram [16];
    logic [DW-1:0] qp  [LAT];
    logic [DW-1:0] qp3 [LAT3];
    always @(posedge clk) begin
        if (!mem_cen && !mem_gwen) sram[mem_a[3:0]] <= mem_d;
        qp[0]  <= sram[mem_a[3:0]];
        qp3[0] <= sram[mem_a3[3:0]];
        for (int s = 1; s < LAT; s++)  qp[s]  <= qp[s-1];
        for (int s = 1; s < LAT3; s++) qp3[s] <= qp3[s-1];
    end
    assign mem_q  = qp[LAT-1];
    assign mem_q3 = qp3[LAT3-1];

    // reference model state
    typedef struct { int due; int ch; logic [DW-1:0] data; } ent_t;
    ent_t          pend[$];
    logic [DW-1:0] ref_mem [16];
    int            ptr = 0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_ch(input int ch, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[ch] = 1'b1;
        req_we[ch]    = we;
        req_addr[ch*AW +: AW]  = a;
        req_wdata[ch*DW +: DW] = d;
    endtask

    task automatic rst_chk();
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cen", mem_cen, 1);
        chk("rst_gwen", mem_gwen, 1);
        chk("rst_A", mem_a, 0);
        chk("rst_D", mem_d, 0);
    endtask

    // One clock of the latency-1 instance checked against the model.
    task automatic step();
        int            g, i;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [NCH-1:0] er;
        ent_t          e;
        @(negedge clk);
        while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
        g = -1;
        for (int k = 0; k < NCH; k++) begin
            i = (ptr + k) % NCH;
            if (g < 0 && req_valid[i]) g = i;
        end
        er = '0;
        a  = '0;
        wd = '0;
        if (g >= 0) begin
            er[g] = 1'b1;
            a  = req_addr[g*AW +: AW];
            wd = req_wdata[g*DW +: DW];
        end
        chk("ready", req_ready, er);
        chk("cen", mem_cen, (g < 0));
        chk("gwen", mem_gwen, (g < 0) ? 1 : !req_we[g]);
        chk("A", mem_a, a);
        chk("D", mem_d, wd);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            chk("rsp_valid", rsp_valid, 64'd1 << pend[0].ch);
            chk("rsp_rdata", rsp_rdata, pend[0].data);
        end else begin
            chk("rsp_valid", rsp_valid, 0);
            chk("rsp_rdata", rsp_rdata, 0);
        end
        chk("busy", busy, (pend.size() > 0));
        if (g >= 0) begin
            e.due = cyc + LAT;
            e.ch  = g;
            if (req_we[g]) begin
`ifdef SRAM_ARB_WR_ACK_EN
                e.data = '0;
                pend.push_back(e);
`endif
                ref_mem[a[3:0]] = wd;
            end else begin
                e.data = ref_mem[a[3:0]];
                pend.push_back(e);
            end
            ptr = (g + 1) % NCH;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] exp_d;
        rst_n = 1'b0; rst3_n = 1'b0;
        idle();
        req_valid = '1;
        v3 = '0; we3 = '0; a3 = '0; d3 = '0;
        @(negedge clk);
        rst_chk();
        @(posedge clk); cyc++; #1;
        rst_n = 1'b1; rst3_n = 1'b1;

        // fill every address through the arbiter
        for (int i = 0; i < 16; i++) begin
            idle();
            set_ch(i % NCH, 1'b1, 64'(i), {$urandom, $urandom});
            step();
        end

        // ch2 reads a known word at address 5
        idle(); set_ch(0, 1'b1, 64'd5, 64'h3C00_4000_4200_3E00); step();
        idle(); set_ch(2, 1'b0, 64'd5, 64'h0);
        #1;
        chk("r033_cen", mem_cen, 0);
        chk("r033_A", mem_a, 5);
        step();
        chk("r033_rsp_valid", rsp_valid, 4'b0100);
        chk("r033_rdata", rsp_rdata, 64'h3C00_4000_4200_3E00);
        idle(); step();

        // ch1 writes, ch0 reads back
        set_ch(1, 1'b1, 64'd7, 64'h1234); step();
`ifdef SRAM_ARB_WR_ACK_EN
        chk("r035_wr_ack", rsp_valid, 4'b0010);
`else
        chk("r035_wr_ack", rsp_valid, 4'b0000);
`endif
        idle(); set_ch(0, 1'b0, 64'd7, 64'h0); step();
        chk("r035_rsp_valid", rsp_valid, 4'b0001);
        chk("r035_rdata", rsp_rdata, 64'h1234);
        idle(); step();

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            idle();
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 1) == 1)
                    set_ch(c, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
            end
            step();
        end

        // reset one cycle after a read grant, then all channels contend
        idle(); set_ch(1, 1'b0, 64'd3, 64'h0); step();
        rst_n = 1'b0;
        pend.delete();
        ptr = 0;
        req_valid = '1;
        @(negedge clk);
        rst_chk();
        @(posedge clk); cyc++; #1;
        rst_n = 1'b1;
        idle();
        for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, 64'(c + 8), 64'h0);
        for (int n = 0; n < 5; n++) step();
        idle();
        for (int n = 0; n < 3; n++) step();

        // latency-3 instance: three back-to-back reads on ch3
        for (int t = 0; t < 8; t++) begin
            v3 = (t < 3) ? 4'b1000 : 4'b0000;
            a3 = '0;
            a3[3*AW +: AW] = 64'(t + 1);
            @(negedge clk);
            exp_d = '0;
            if (t >= 3 && t <= 5) exp_d = ref_mem[t-2];
            chk("l3_ready", rdy3, (t < 3) ? 4'b1000 : 4'b0000);
            chk("l3_A", mem_a3, (t < 3) ? 64'(t + 1) : 64'd0);
            chk("l3_rsp_valid", rsp3, (t >= 3 && t <= 5) ? 4'b1000 : 4'b0000);
            chk("l3_rdata", rdata3, exp_d);
            chk("l3_busy", busy3, (t >= 1 && t <= 5));
            @(posedge clk); #1;
        end

        // latency-3 instance: reset drops the read in flight
        v3 = 4'b1000; a3 = '0; a3[3*AW +: AW] = 64'd2;
        @(negedge clk);
        chk("l3r_ready", rdy3, 4'b1000);
        @(posedge clk); #1;
        v3 = '0;
        @(posedge clk); #1;
        rst3_n = 1'b0;
        v3 = '1;
        @(negedge clk);
        chk("l3r_rst_ready", rdy3, 0);
        chk("l3r_rst_rsp", rsp3, 0);
        chk("l3r_rst_busy", busy3, 0);
        chk("l3r_rst_cen", mem_cen3, 1);
        chk("l3r_rst_rdata", rdata3, 0);
        @(posedge clk); #1;
        rst3_n = 1'b1;
        v3 = '0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("l3r_no_rsp", rsp3, 0);
            chk("l3r_no_busy", busy3, 0);
            @(posedge clk); #1;
        end
        v3 = 4'b1010;
        @(negedge clk);
        chk("l3r_first_grant", rdy3, 4'b0010);
        @(posedge clk); #1;
        v3 = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
